// File: rtl/core_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_pipe_if
//  Description : Instruction-in / result-out handshake bundle for core_pipe.
//                Optional flags output is present when CORE_PIPE_FLAGS_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_pipe_if #(
    parameter int DATA_WIDTH = 8
);
    logic [31:0]           i_instr;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data1;
    logic                  o_valid1;
    logic                  i_ready1;
    logic                  o_err;
`ifdef CORE_PIPE_FLAGS_EN
    logic [1:0]            o_flags;
`endif

    // Instruction source / result sink side
    modport master (
        output i_instr, i_valid, i_ready1,
        input  o_ready, o_data1, o_valid1, o_err
`ifdef CORE_PIPE_FLAGS_EN
        , input o_flags
`endif
    );

    // Core side
    modport slave (
        input  i_instr, i_valid, i_ready1,
        output o_ready, o_data1, o_valid1, o_err
`ifdef CORE_PIPE_FLAGS_EN
        , output o_flags
`endif
    );
endinterface
`default_nettype wire

// File: rtl/core_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : core_pipe
//  Description : Small in-order core. Instructions are buffered in a FIFO and
//                run through a DEC -> EXE -> OUT sequence against a register
//                file; each result is offered on a valid/ready output.
//                Optional macro CORE_PIPE_FLAGS_EN adds o_flags = {carry, zero}.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int NREGS      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic  i_CLK,
    input  wire logic  i_RSTn,
    core_pipe_if.slave bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        EXE  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // ---------------- instruction FIFO ----------------
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    // ---------------- core state ----------------
    state_t                state;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  err_q;

    // ---------------- decode / execute ----------------
    logic [3:0]            opcode;
    logic [AW-1:0]         rd_idx;
    logic [AW-1:0]         rs0_idx;
    logic [AW-1:0]         rs1_idx;
    logic [31:0]           imm_ext;
    logic [DATA_WIDTH-1:0] rs0_val;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH:0]   alu_wide;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_illegal;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign head       = fifo_mem[rd_ptr];
    assign push       = bus.i_valid && !fifo_full;

    // Pops happen only on the three transitions that load the next instruction.
    assign pop = !fifo_empty &&
                 ((state == IDLE) ||
                  (state == EXE && alu_illegal) ||
                  (state == OUT && bus.i_ready1));

    assign opcode  = instr[3:0];
    assign rd_idx  = instr[4 +: AW];
    assign rs0_idx = instr[9 +: AW];
    assign rs1_idx = instr[14 +: AW];
    assign imm_ext = {19'd0, instr[31:19]};

    // Register 0 is hardwired to zero on read.
    assign rs0_val = (rs0_idx == '0) ? '0 : regs[rs0_idx];
    assign rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];

    assign alu_result = alu_wide[DATA_WIDTH-1:0];

    // Register-index bits above log2(NREGS) and immediate bits above the
    // datapath width are intentionally ignored.
    logic unused_bits;
`ifdef CORE_PIPE_FLAGS_EN
    assign unused_bits = ^{instr, imm_ext};
`else
    assign unused_bits = ^{instr, imm_ext, alu_wide[DATA_WIDTH]};
`endif

    assign bus.o_ready  = !fifo_full;
    assign bus.o_data1  = data_q;
    assign bus.o_valid1 = valid_q;
    assign bus.o_err    = err_q;

    // ALU: extra top bit carries the ADD carry-out / SUB borrow.
    always_comb begin
        alu_wide    = '0;
        alu_illegal = 1'b0;
        case (opcode)
            OP_ADD:  alu_wide = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  alu_wide = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  alu_wide = {1'b0, op_a & op_b};
            OP_OR:   alu_wide = {1'b0, op_a | op_b};
            OP_XOR:  alu_wide = {1'b0, op_a ^ op_b};
            OP_LDI:  alu_wide = {1'b0, imm_ext[DATA_WIDTH-1:0]};
            default: alu_illegal = 1'b1;
        endcase
    end

    // Instruction buffer storage, pointers and occupancy.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.i_instr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: fetch, operand read, execute/writeback, output handshake.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state   <= IDLE;
            instr   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        instr <= head;
                        state <= DEC;
                    end
                end
                DEC: begin
                    op_a  <= rs0_val;
                    op_b  <= rs1_val;
                    state <= EXE;
                end
                EXE: begin
                    if (alu_illegal) begin
                        err_q <= 1'b1;
                        if (pop) begin
                            instr <= head;
                            state <= DEC;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        data_q  <= alu_result;
                        valid_q <= 1'b1;
                        if (rd_idx != '0) regs[rd_idx] <= alu_result;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (bus.i_ready1) begin
                        valid_q <= 1'b0;
                        if (pop) begin
                            instr <= head;
                            state <= DEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CORE_PIPE_FLAGS_EN
    logic [1:0] flags_q;
    assign bus.o_flags = flags_q;

    // Flags are captured alongside the result so they track o_valid1.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            flags_q <= 2'b00;
        end else if (state == EXE && !alu_illegal) begin
            flags_q <= {alu_wide[DATA_WIDTH], (alu_result == '0)};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_pipe
//  Description : Directed self-checking bench for core_pipe (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_pipe;
    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    core_pipe_if #(.DATA_WIDTH(8)) bus ();

    core_pipe #(
        .DATA_WIDTH (8),
        .NREGS      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .i_CLK  (clk),
        .i_RSTn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input int op, input int rd, input int rs0,
                                       input int rs1, input int imm);
        logic [31:0] o, d, a, b, m;
        o = op; d = rd; a = rs0; b = rs1; m = imm;
        return {m[12:0], b[4:0], a[4:0], d[4:0], o[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] ins);
        int n;
        n = 0;
        bus.i_instr = ins;
        bus.i_valid = 1'b1;
        while (!bus.o_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Waits (bounded) for a result, checks it, then lets the handshake edge pass.
    task automatic wait_out(input string tag, input logic [31:0] exp, input logic [1:0] expf);
        int n;
        n = 0;
        while (!bus.o_valid1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, bus.o_valid1}, 32'd1);
        chk({tag, "_data"}, {24'd0, bus.o_data1}, exp);
`ifdef CORE_PIPE_FLAGS_EN
        chk({tag, "_flags"}, {30'd0, bus.o_flags}, {30'd0, expf});
`else
        if (expf == 2'b11) $display("note: unexpected flag argument");
`endif
        if (bus.i_ready1) @(negedge clk);
    endtask

    initial begin
        int errs;
        int nout;
        logic [7:0] outs [4];

        tests = 0;
        fails = 0;
        rstn = 1'b0;
        bus.i_instr  = '0;
        bus.i_valid  = 1'b0;
        bus.i_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_valid", {31'd0, bus.o_valid1}, 32'd0);
        chk("rst_data",  {24'd0, bus.o_data1}, 32'd0);
        chk("rst_err",   {31'd0, bus.o_err}, 32'd0);
        chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);

        // Latency from idle: LDI r1=5
        bus.i_ready1 = 1'b1;
        send(mk(5, 1, 0, 0, 5));
        chk("lat_e1", {31'd0, bus.o_valid1}, 32'd0);
        @(negedge clk);
        chk("lat_e2", {31'd0, bus.o_valid1}, 32'd0);
        @(negedge clk);
        chk("lat_e3", {31'd0, bus.o_valid1}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'd0, bus.o_valid1}, 32'd1);
        chk("lat_data",  {24'd0, bus.o_data1}, 32'd5);
        @(negedge clk);
        chk("lat_drop", {31'd0, bus.o_valid1}, 32'd0);

        send(mk(5, 2, 0, 0, 3));
        wait_out("ldi_r2", 32'd3, 2'b00);
        send(mk(0, 3, 1, 2, 0));
        wait_out("add_r3", 32'd8, 2'b00);

        // Arithmetic with carry / borrow, logic ops, truncation, zero flag
        send(mk(5, 1, 0, 0, 200));
        wait_out("ldi200", 32'd200, 2'b00);
        send(mk(5, 2, 0, 0, 100));
        wait_out("ldi100", 32'd100, 2'b00);
        send(mk(0, 5, 1, 2, 0));
        wait_out("add_ovf", 32'd44, 2'b10);
        send(mk(1, 6, 2, 1, 0));
        wait_out("sub_brw", 32'd156, 2'b10);
        send(mk(1, 6, 1, 2, 0));
        wait_out("sub_ok", 32'd100, 2'b00);
        send(mk(2, 7, 1, 2, 0));
        wait_out("and", 32'd64, 2'b00);
        send(mk(3, 8, 1, 2, 0));
        wait_out("or", 32'd236, 2'b00);
        send(mk(4, 9, 1, 2, 0));
        wait_out("xor", 32'd172, 2'b00);
        send(mk(4, 9, 1, 1, 0));
        wait_out("xor_zero", 32'd0, 2'b01);
        send(mk(5, 9, 0, 0, 'h1234));
        wait_out("ldi_trunc", 32'h34, 2'b00);

        // Back-pressure: 1 in OUT + 4 buffered fills the FIFO
        bus.i_ready1 = 1'b0;
        for (int i = 0; i < 5; i++) send(mk(5, 10 + i, 0, 0, 11 + i));
        chk("full_ready", {31'd0, bus.o_ready}, 32'd0);
        chk("full_hold", {24'd0, bus.o_data1}, 32'd11);
        bus.i_ready1 = 1'b1;
        wait_out("bp0", 32'd11, 2'b00);
        wait_out("bp1", 32'd12, 2'b00);
        wait_out("bp2", 32'd13, 2'b00);
        wait_out("bp3", 32'd14, 2'b00);
        wait_out("bp4", 32'd15, 2'b00);

        // Illegal opcode between two LDIs
        send(mk(5, 11, 0, 0, 'h21));
        send(mk(9, 12, 0, 0, 'h7));
        send(mk(5, 12, 0, 0, 'h22));
        errs = 0;
        nout = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_err) errs++;
            if (bus.o_valid1 && nout < 4) begin
                outs[nout] = bus.o_data1;
                nout++;
            end
            @(negedge clk);
        end
        chk("ill_errs", errs, 32'd1);
        chk("ill_nout", nout, 32'd2);
        chk("ill_out0", {24'd0, outs[0]}, 32'h21);
        chk("ill_out1", {24'd0, outs[1]}, 32'h22);

        // Register 0 stays zero
        send(mk(5, 0, 0, 0, 7));
        wait_out("r0_ldi", 32'd7, 2'b00);
        send(mk(3, 4, 0, 0, 0));
        wait_out("r0_or", 32'd0, 2'b01);

        // Asynchronous reset while in EXE, with one instruction still buffered
        send(mk(5, 13, 0, 0, 'h55));
        send(mk(5, 14, 0, 0, 'h66));
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("ar_valid", {31'd0, bus.o_valid1}, 32'd0);
        chk("ar_data",  {24'd0, bus.o_data1}, 32'd0);
        chk("ar_ready", {31'd0, bus.o_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.o_valid1) nout++;
            @(negedge clk);
        end
        chk("ar_fifo_empty", nout, 32'd0);
        send(mk(0, 15, 1, 2, 0));
        wait_out("ar_regs_zero", 32'd0, 2'b01);
        send(mk(5, 1, 0, 0, 9));
        wait_out("ar_next", 32'd9, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
